// File: rtl/input_pkg.sv
// Shared types and constants for the switch input controller.
package input_pkg;

  // Maximum number of hex digits the accumulator holds (32 bits / 4 bits).
  localparam int NUM_DIGITS = 8;

  // Controller modes: typing digits, accumulator full, word awaiting the core.
  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    FULL    = 2'd1,
    PENDING = 2'd2
  } input_state_e;

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each debounced 0->1 transition.
module button_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic n_rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(32'(DEBOUNCE_CYCLES) + 1);
  // Counter value reached on the last of the required consecutive samples.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 20'd1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic          level_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          press_reg;
  logic          press_next;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], btn};
    end
  end

  // Count consecutive synchronized samples that disagree with the debounced
  // level; any agreeing sample restarts the count, so short bounces never
  // flip the level.
  always_comb begin
    level_next = level_reg;
    cnt_next   = '0;
    if (sync_reg[1] != level_reg) begin
      if (cnt_reg == CNT_LAST) begin
        level_next = sync_reg[1];
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
    press_next = level_next & ~level_reg;
  end

  // Debounced level, stability counter and registered press pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
    end else begin
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
      press_reg <= press_next;
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/switch_input_controller.sv
// Hex-entry front panel: debounced buttons build a 32-bit word from the
// switches and hand it to the core through a valid/ack register.
module switch_input_controller
  import input_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [3:0]  sw,
  input  logic        btn_enter,
  input  logic        btn_clear,
  input  logic        btn_submit,
  input  logic        read_ack,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic [31:0] entry_value,
  output logic [3:0]  digit_count
);

  // Button lanes: 0 = enter, 1 = clear, 2 = submit.
  logic [2:0] btn_raw;
  logic [2:0] btn_press;

  assign btn_raw = {btn_submit, btn_clear, btn_enter};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk  (clk),
        .n_rst(n_rst),
        .btn  (btn_raw[gi]),
        .press(btn_press[gi])
      );
    end
  endgenerate

  logic enter_pulse;
  logic clear_pulse;
  logic submit_pulse;

  assign enter_pulse  = btn_press[0];
  assign clear_pulse  = btn_press[1];
  assign submit_pulse = btn_press[2];

  input_state_e state_reg;
  input_state_e state_next;
  logic [31:0]  entry_value_reg;
  logic [31:0]  entry_value_next;
  logic [3:0]   digit_count_reg;
  logic [3:0]   digit_count_next;
  logic [31:0]  read_data_reg;
  logic [31:0]  read_data_next;
  logic         read_valid_reg;
  logic         read_valid_next;

  // Controller state and all output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg       <= ENTRY;
      entry_value_reg <= '0;
      digit_count_reg <= '0;
      read_data_reg   <= '0;
      read_valid_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      entry_value_reg <= entry_value_next;
      digit_count_reg <= digit_count_next;
      read_data_reg   <= read_data_next;
      read_valid_reg  <= read_valid_next;
    end
  end

  // Button handling with clear > submit > enter; the core handshake is
  // independent of the buttons so an ack is never lost to a clear.
  always_comb begin
    state_next       = state_reg;
    entry_value_next = entry_value_reg;
    digit_count_next = digit_count_reg;
    read_data_next   = read_data_reg;
    read_valid_next  = read_valid_reg;

    if (clear_pulse) begin
      entry_value_next = '0;
      digit_count_next = '0;
      if (state_reg == FULL) begin
        state_next = ENTRY;
      end
    end else if (submit_pulse && (state_reg != PENDING)) begin
      read_data_next   = entry_value_reg;
      read_valid_next  = 1'b1;
      entry_value_next = '0;
      digit_count_next = '0;
      state_next       = PENDING;
    end else if (enter_pulse && (state_reg == ENTRY)) begin
      entry_value_next = {entry_value_reg[27:0], sw};
      digit_count_next = digit_count_reg + 4'd1;
      if (digit_count_next == 4'(NUM_DIGITS)) begin
        state_next = FULL;
      end
    end

    if ((state_reg == PENDING) && read_valid_reg && read_ack) begin
      read_valid_next = 1'b0;
      state_next      = ENTRY;
    end
  end

  assign read_data   = read_data_reg;
  assign read_valid  = read_valid_reg;
  assign entry_value = entry_value_reg;
  assign digit_count = digit_count_reg;

endmodule

// File: doc/switch_input_controller.md
SWITCH_INPUT_CONTROLLER -- requirements
Module: switch_input_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20'd1_000_000, giving the number of consecutive stable synchronized samples that qualify a button press.
REQ-002 The block SHALL have port clk, input, 1, the single system clock.
REQ-003 The block SHALL have port n_rst, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port sw, input, 4, the hex digit value from the board switches (treated as quasi-static).
REQ-005 The block SHALL have ports btn_enter, btn_clear and btn_submit, each input, 1, raw asynchronous pushbuttons, active-high.
REQ-006 The block SHALL have port read_ack, input, 1, driven high by the core when it consumes read_data.
REQ-007 The block SHALL have port read_data, output, 32, the submitted word offered to the core.
REQ-008 The block SHALL have port read_valid, output, 1, high while read_data holds an unconsumed word.
REQ-009 The block SHALL have port entry_value, output, 32, the accumulator being typed (for the display path).
REQ-010 The block SHALL have port digit_count, output, 4, the number of digits entered, 0..8.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer followed by a stability counter.
REQ-012 A one-cycle press pulse SHALL be emitted when the debounced level goes 0->1; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples that differ from it.
REQ-013 Bounces shorter than DEBOUNCE_CYCLES SHALL produce no pulse, and a held button SHALL produce exactly one pulse.
REQ-014 The FSM SHALL have states ENTRY, FULL and PENDING.
REQ-015 In ENTRY, an enter pulse SHALL set entry_value to {entry_value[27:0], sw} and increment digit_count; when digit_count reaches 8, the FSM SHALL go to FULL.
REQ-016 In FULL, enter pulses SHALL be ignored, so entry_value and digit_count stay unchanged.
REQ-017 In ENTRY or FULL, a submit pulse SHALL copy entry_value to read_data, set read_valid the next cycle, clear entry_value and digit_count, and go to PENDING.
REQ-018 Submit with digit_count=0 SHALL be legal and SHALL present 32'h0.
REQ-019 In PENDING, enter and submit pulses SHALL be ignored, while clear remains effective on the accumulator only.
REQ-020 In PENDING, read_ack=1 while read_valid=1 SHALL drop read_valid on the next cycle and move the FSM to ENTRY.
REQ-021 read_ack while read_valid=0 SHALL be ignored.
REQ-022 read_data SHALL be stable while read_valid=1.
REQ-023 A clear pulse SHALL zero entry_value and digit_count in any state and SHALL return FULL to ENTRY; clear SHALL NOT affect read_data or read_valid.
REQ-024 Priority of simultaneous pulses SHALL be clear > submit > enter; a lower-priority pulse in the same cycle is discarded.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 Asserting n_rst SHALL immediately force FSM=ENTRY, entry_value=0, digit_count=0, read_data=0, read_valid=0, all synchronizers and debounced levels to 0, and all counters to 0.
REQ-027 Reset mid-entry or while PENDING SHALL discard the accumulated and pending data.
REQ-028 After reset is released, a button already held high SHALL still produce one pulse after debouncing.

Structure
REQ-029 A shared package input_pkg SHALL hold the state enum (ENTRY, FULL, PENDING) and NUM_DIGITS=8.
REQ-030 Debouncing SHALL be a sub-module button_debounce (sync, counter, rising-edge pulse), instantiated three times.
REQ-031 The stability counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (DEBOUNCE_CYCLES=4)
REQ-032 Scenario 1: enter with sw=4'hA, then 4'h5 -> entry_value=32'h0000_00A5, digit_count=2.
REQ-033 Scenario 2: 9 enters with sw=1..9 -> entry_value=32'h1234_5678, digit_count=8, and the 9th enter is ignored.
REQ-034 Scenario 3: submit after scenario 1 -> read_valid=1 with read_data=32'h0000_00A5 and entry_value=0; read_ack for 1 cycle -> read_valid=0 the next cycle; a second submit before the ack is ignored.
REQ-035 Scenario 4: btn_enter toggled every 2 cycles for 20 cycles, then held -> exactly one pulse and one digit entered.
REQ-036 Scenario 5: clear and submit pulses in the same cycle with 3 digits entered -> accumulator cleared and read_valid stays 0.
REQ-037 Scenario 6: n_rst asserted while PENDING with read_data=32'hDEAD_BEEF -> read_valid=0 and read_data=0 immediately, without waiting for a clock edge.
